mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one synchronous single-port RAM between the core's instruction-fetch port (I) and
//  load/store port (D). Sits between the RISC-V core and the unified memory.
//  Provides a req/gnt handshake on each port and routes in-order read responses back
//  MEM_LAT cycles after each grant.
//  D has priority; a streak counter bounds fetch starvation. Fetch flush kills stale responses.
// PARAMETERS
//  ADDR_W        32  address width, byte address
//  DATA_W        32  data width; byte enables are DATA_W/8 bits
//  MEM_LAT       1   RAM read latency in cycles, legal range 1..4
//  MAX_D_STREAK  4   consecutive D grants allowed while i_req is pending (>=1)
// PORTS
//  clk         in   1         system clock, rising edge
//  rst_n       in   1         asynchronous active-low reset
//  i_req       in   1         fetch request
//  i_addr      in   ADDR_W    fetch address
//  i_flush     in   1         discard all in-flight fetch responses
//  i_gnt       out  1         fetch request accepted this cycle
//  i_rvalid    out  1         fetch response valid
//  i_rdata     out  DATA_W    fetch response data
//  d_req       in   1         data request
//  d_we        in   1         1 = write, 0 = read
//  d_be        in   DATA_W/8  byte enables for writes
//  d_addr      in   ADDR_W    data address
//  d_wdata     in   DATA_W    write data
//  d_gnt       out  1         data request accepted this cycle
//  d_rvalid    out  1         data response valid (read data or write ack)
//  d_rdata     out  DATA_W    read data; 0 on a write ack
//  mem_ce      out  1         RAM access strobe
//  mem_we      out  1         RAM write enable
//  mem_be      out  DATA_W/8  RAM byte enables
//  mem_addr    out  ADDR_W    RAM address
//  mem_wdata   out  DATA_W    RAM write data
//  mem_rdata   in   DATA_W    RAM read data, valid MEM_LAT cycles after mem_ce
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - Tag pipeline and streak counter are cleared.
//   - While rst_n=0, all gnt, rvalid, mem_ce and mem_we are 0; all data outputs are 0.
//   - Requests in flight when reset asserts never produce a response after release.
//  Grant (combinational, same cycle as req)
//   - Only one of i_gnt/d_gnt is 1 in any cycle. mem_ce = i_gnt | d_gnt.
//   - Default: d_req wins over i_req.
//   - I wins if i_req=1 and streak == MAX_D_STREAK; the winning grant clears streak.
//  Streak counter
//   - Increments, saturating, on each d_gnt while i_req=1.
//   - Clears when i_req=0 or on i_gnt.
//  Mem mux
//   - The winner's addr/we/be/wdata drive mem_*.
//   - An I access drives mem_we=0 and mem_be=all ones.
//   - With no grant, mem_* = 0.
//  Handshake
//   - A requester holds req/addr/data stable until its gnt.
//   - One access may be granted every cycle; there is no outstanding-transaction limit.
//  Response
//   - Each grant pushes tag {valid, owner, killed} into a MEM_LAT-deep shift register.
//   - At the tail, the owner gets a rvalid pulse.
//   - rdata = mem_rdata for reads; 0 for D write acks and for any non-valid cycle.
//   - Responses are strictly in grant order.
//  Flush
//   - i_flush=1 sets killed on every I tag already in the pipeline.
//   - A killed tag reaching the tail yields no i_rvalid.
//   - A fetch granted in the same cycle as i_flush is NOT killed.
//   - D tags are never affected by i_flush.
// STRUCTURE
//  Package mem_arb_pkg
//   - Owner encoding OWN_I=1'b0, OWN_D=1'b1.
//   - Tag struct/width constant {valid, owner, killed, we}.
//   - MAX_MEM_LAT=4.
//  Sub-module mem_arb_resp_pipe
//   - Tag shift register with flush-kill and tail decode.
//   - Arbitration and the streak counter stay in the top module.
// TESTING
//  1. Read path: i_req, i_addr=0x10, mem word 0x00000013
//     -> i_gnt same cycle; i_rvalid with i_rdata=0x00000013 exactly MEM_LAT cycles later.
//  2. Contention: i_req and d_req held high for 10 cycles, MAX_D_STREAK=4
//     -> grant order DDDDIDDDDI; no cycle with both gnt high.
//  3. Flush: two fetches granted, then i_flush in the cycle of a third fetch grant
//     -> only the third fetch returns i_rvalid.
//  4. Write then read: D write 0xDEADBEEF to 0x40 with d_be=4'b0011, then read 0x40
//     -> d_rvalid with d_rdata=0 (write ack), then d_rdata=0x????BEEF
//        (upper half keeps its prior contents).
//  5. Reset mid-operation: rst_n pulsed low with 2 tags in flight
//     -> no rvalid after release; streak=0; first cycle after release grants D over I.
//  6. Back-to-back D reads to 0x0,0x4,0x8 with MEM_LAT=3
//     -> three consecutive d_rvalid in the same order, no gaps.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Owner encoding, the response tag layout and the latency ceiling live here.
package mem_arb_pkg;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int MAX_MEM_LAT = 4;

    typedef struct packed {
        logic valid;
        logic owner;
        logic killed;
        logic we;
    } arb_tag_t;

    localparam int TAG_W = $bits(arb_tag_t);

    function automatic arb_tag_t make_tag(input logic valid, input logic owner, input logic we);
        arb_tag_t t;
        t.valid  = valid;
        t.owner  = owner;
        t.killed = 1'b0;
        t.we     = we;
        return t;
    endfunction

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Response tag pipeline: one tag per granted access, aligned with RAM read latency.
// Decodes the tail tag into per-port rvalid/rdata and applies fetch flushes.
module mem_arb_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    input  logic              push_owner,
    input  logic              push_we,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata
);

    arb_tag_t pipe_q [MEM_LAT];
    arb_tag_t pipe_d [MEM_LAT];
    arb_tag_t tail;

    // The incoming tag is never killed; only tags already in flight see the flush.
    always_comb begin
        pipe_d[0] = make_tag(push_valid, push_owner, push_we);
        for (int s = 1; s < MEM_LAT; s++) begin
            pipe_d[s] = pipe_q[s-1];
            if (flush && pipe_q[s-1].valid && pipe_q[s-1].owner == OWN_I) begin
                pipe_d[s].killed = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < MEM_LAT; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < MEM_LAT; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    // A fetch response at the tail in the same cycle as a flush is stale as well.
    always_comb begin
        tail     = pipe_q[MEM_LAT-1];
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (tail.valid && tail.owner == OWN_I && !tail.killed && !flush) begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
        end
        if (tail.valid && tail.owner == OWN_D) begin
            d_rvalid = 1'b1;
            if (!tail.we) begin
                d_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port RAM between fetch (I) and load/store (D) ports.
// D has priority; a streak counter forces an I grant after MAX_D_STREAK D grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (i_req && (!d_req || streak_q == STREAK_MAX)) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!i_req || i_gnt) begin
            streak_d = '0;
        end else if (d_gnt && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt) begin
            mem_ce   = 1'b1;
            mem_be   = '1;
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_ce    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    mem_arb_resp_pipe #(
        .MEM_LAT (MEM_LAT),
        .DATA_W  (DATA_W)
    ) u_resp_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (mem_ce),
        .push_owner (d_gnt ? OWN_D : OWN_I),
        .push_we    (mem_we),
        .flush      (i_flush),
        .mem_rdata  (mem_rdata),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small latency-accurate RAM model.
// Runs with MEM_LAT=3 and MAX_D_STREAK=4.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LAT        = 3;
    localparam int MAX_STREAK = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req, i_flush, i_gnt, i_rvalid;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_ce, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [31:0] ram [0:63];
    logic [31:0] rd_pipe [0:LAT-1];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MEM_LAT      (LAT),
        .MAX_D_STREAK (MAX_STREAK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // RAM model: preloaded while in reset, byte-enabled writes, reads return LAT cycles later.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                ram[i] <= 32'h1000_0000 + 32'(i);
            end
            ram[4]  <= 32'h0000_0013;
            ram[16] <= 32'h1234_5678;
        end else if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        rd_pipe[0] <= (mem_ce && !mem_we) ? ram[mem_addr[7:2]] : 32'hFFFF_FFFF;
        for (int s = 1; s < LAT; s++) begin
            rd_pipe[s] <= rd_pipe[s-1];
        end
    end

    assign mem_rdata = rd_pipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic iflush,
                                 input logic dreq, input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] daddr, input logic [31:0] dwdata);
        i_req   = ireq;
        i_addr  = iaddr;
        i_flush = iflush;
        d_req   = dreq;
        d_we    = dwe;
        d_be    = dbe;
        d_addr  = daddr;
        d_wdata = dwdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Requests pending while reset is held must not be granted.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hAAAA_5555);
        #3;
        checkOutput("rst_i_gnt", 32'(i_gnt), 32'd0);
        checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
        checkOutput("rst_mem_ce", 32'(mem_ce), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        tick();
        idle();
        rst_n = 1'b1;
        #3;
        checkOutput("idle_mem_ce", 32'(mem_ce), 32'd0);
        checkOutput("idle_mem_be", 32'(mem_be), 32'd0);
        checkOutput("idle_i_rvalid", 32'(i_rvalid), 32'd0);
        checkOutput("idle_d_rvalid", 32'(d_rvalid), 32'd0);
        tick();

        // Test 1: single fetch returns after exactly LAT cycles.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #3;
        checkOutput("t1_i_gnt", 32'(i_gnt), 32'd1);
        checkOutput("t1_d_gnt", 32'(d_gnt), 32'd0);
        checkOutput("t1_mem_addr", mem_addr, 32'h10);
        checkOutput("t1_mem_we", 32'(mem_we), 32'd0);
        checkOutput("t1_mem_be", 32'(mem_be), 32'hF);
        tick();
        idle();
        for (int c = 1; c <= LAT; c++) begin
            #3;
            checkOutput("t1_i_rvalid", 32'(i_rvalid), 32'(c == LAT));
            checkOutput("t1_i_rdata", i_rdata, (c == LAT) ? 32'h13 : 32'h0);
            tick();
        end

        // Test 2: sustained contention gives DDDDIDDDDI.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
            #3;
            checkOutput("t2_i_gnt", 32'(i_gnt), 32'(c == 4 || c == 9));
            checkOutput("t2_d_gnt", 32'(d_gnt), 32'(c != 4 && c != 9));
            checkOutput("t2_one_hot", 32'(i_gnt & d_gnt), 32'd0);
            tick();
        end
        idle();
        repeat (LAT + 1) tick();

        // Test 3: flush in the cycle of the third fetch kills only the first two.
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                applyStimulus(1'b1, 32'(c * 4), 1'(c == 2), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end else begin
                idle();
            end
            #3;
            if (c < 3) begin
                checkOutput("t3_i_gnt", 32'(i_gnt), 32'd1);
            end
            checkOutput("t3_i_rvalid", 32'(i_rvalid), 32'(c == 5));
            checkOutput("t3_i_rdata", i_rdata, (c == 5) ? 32'h1000_0002 : 32'h0);
            tick();
        end

        // Test 4: partial write, then read back merged word.
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
            end else if (c == 1) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
            end else begin
                idle();
            end
            #3;
            if (c == 0) begin
                checkOutput("t4_wr_gnt", 32'(d_gnt), 32'd1);
                checkOutput("t4_mem_we", 32'(mem_we), 32'd1);
                checkOutput("t4_mem_be", 32'(mem_be), 32'h3);
                checkOutput("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
            if (c == 1) begin
                checkOutput("t4_rd_gnt", 32'(d_gnt), 32'd1);
                checkOutput("t4_rd_mem_we", 32'(mem_we), 32'd0);
            end
            checkOutput("t4_d_rvalid", 32'(d_rvalid), 32'(c >= 3));
            checkOutput("t4_d_rdata", d_rdata, (c == 4) ? 32'h1234_BEEF : 32'h0);
            tick();
        end

        // Test 5: reset with two fetches in flight.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 32'(c * 4), 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            #3;
            checkOutput("t5_pre_i_gnt", 32'(i_gnt), 32'd1);
            tick();
        end
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        rst_n = 1'b0;
        #3;
        checkOutput("t5_rst_i_gnt", 32'(i_gnt), 32'd0);
        checkOutput("t5_rst_d_gnt", 32'(d_gnt), 32'd0);
        checkOutput("t5_rst_mem_ce", 32'(mem_ce), 32'd0);
        checkOutput("t5_rst_i_rvalid", 32'(i_rvalid), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #3;
            checkOutput("t5_i_gnt", 32'(i_gnt), 32'(c == 4));
            checkOutput("t5_d_gnt", 32'(d_gnt), 32'(c != 4));
            checkOutput("t5_i_rvalid", 32'(i_rvalid), 32'(c == 7));
            checkOutput("t5_d_rvalid", 32'(d_rvalid), 32'(c >= 3 && c <= 6));
            tick();
        end
        idle();
        repeat (LAT + 1) tick();

        // Test 6: back-to-back D reads return in order without gaps.
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'(c * 4), 32'h0);
            end else begin
                idle();
            end
            #3;
            if (c < 3) begin
                checkOutput("t6_d_gnt", 32'(d_gnt), 32'd1);
            end
            checkOutput("t6_d_rvalid", 32'(d_rvalid), 32'(c >= 3));
            checkOutput("t6_d_rdata", d_rdata, (c >= 3) ? 32'h1000_0000 + 32'(c - 3) : 32'h0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
